// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared state encoding and reference truth tables for the gate sweep checker
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_t;

  // Bit v is the expected output for input vector v.
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_sweep_checker_timer.sv
// rtl/gate_sweep_checker_timer.sv - per-vector hold counter, flags the last cycle of the hold window
module sweep_hold_timer #(
  parameter int HOLD = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  logic [CW-1:0] r_cnt;

  // Counter parks on LAST so a missed clear can never wrap past the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps all input vectors of a small gate and checks its output against TRUTH
// Optional first-failure capture ports are enabled by defining SWEEP_ERRLOG_EN.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int                    N_IN  = 2,
  parameter int                    HOLD  = 5,
  parameter logic [(2**N_IN)-1:0]  TRUTH = TT_AND2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt
`ifdef SWEEP_ERRLOG_EN
  ,
  output logic            first_fail_vld,
  output logic [N_IN-1:0] first_fail_vec
`endif
);

  if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
    $error("gate_sweep_checker: N_IN must be in 1..4");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("gate_sweep_checker: HOLD must be >= 1");
  end

  localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};

  sweep_state_t    r_state;
  logic [N_IN-1:0] r_vec;
  logic [N_IN:0]   r_err;

  logic w_start_ok;
  logic w_last;
  logic w_sample;
  logic w_mismatch;
  logic w_last_vec;

  // start is only honoured outside a sweep.
  assign w_start_ok = start && (r_state != ST_DRIVE);
  assign w_sample   = (r_state == ST_DRIVE) && w_last;
  assign w_mismatch = w_sample && (dut_out != TRUTH[r_vec]);
  assign w_last_vec = (r_vec == VEC_MAX);

  sweep_hold_timer #(
    .HOLD (HOLD)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start_ok || w_sample),
    .i_en   (r_state == ST_DRIVE),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_err   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_DRIVE;
            r_vec   <= '0;
            r_err   <= '0;
          end
        end
        ST_DRIVE: begin
          if (w_sample) begin
            if (w_mismatch) begin
              r_err <= r_err + 1'b1;
            end
            if (w_last_vec) begin
              r_state <= ST_DONE;
            end else begin
              r_vec <= r_vec + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SWEEP_ERRLOG_EN
  logic            r_ff_vld;
  logic [N_IN-1:0] r_ff_vec;

  // Only the first mismatch of a sweep is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_vld <= 1'b0;
      r_ff_vec <= '0;
    end else if (w_start_ok) begin
      r_ff_vld <= 1'b0;
      r_ff_vec <= '0;
    end else if (w_mismatch && !r_ff_vld) begin
      r_ff_vld <= 1'b1;
      r_ff_vec <= r_vec;
    end
  end

  assign first_fail_vld = r_ff_vld;
  assign first_fail_vec = r_ff_vec;
`endif

  assign dut_in  = r_vec;
  assign busy    = (r_state == ST_DRIVE);
  assign done    = (r_state == ST_DONE);
  assign pass    = (r_state == ST_DONE) && (r_err == '0);
  assign err_cnt = r_err;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - randomized self-checking bench for gate_sweep_checker with a behavioural gate model
module tb_gate_sweep_checker;
  import gate_sweep_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         failures = 0;

  // Default-configuration checker (HOLD=5, AND truth table)
  logic       start = 1'b0;
  logic [1:0] d_in;
  logic       d_out;
  logic       busy, done, pass;
  logic [2:0] err_cnt;
  int         g_mode = 0;
  logic [3:0] g_tab = 4'd0;
  logic       g_glitch = 1'b0;
  logic       g_y;

  // HOLD=1 checker with XOR truth table
  logic       x_start = 1'b0;
  logic [1:0] x_in;
  logic       x_out;
  logic       x_busy, x_done, x_pass;
  logic [2:0] x_err;
  int         x_mode = 0;
  logic [3:0] x_tab = 4'd0;

`ifdef SWEEP_ERRLOG_EN
  logic       ff_vld, x_ff_vld;
  logic [1:0] ff_vec, x_ff_vec;
`endif

  always #5 clk = ~clk;

  gate_sweep_checker u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dut_in  (d_in),
    .dut_out (d_out),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt)
`ifdef SWEEP_ERRLOG_EN
    ,
    .first_fail_vld (ff_vld),
    .first_fail_vec (ff_vec)
`endif
  );

  gate_sweep_checker #(.N_IN(2), .HOLD(1), .TRUTH(TT_XOR2)) u_xor (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (x_start),
    .dut_in  (x_in),
    .dut_out (x_out),
    .busy    (x_busy),
    .done    (x_done),
    .pass    (x_pass),
    .err_cnt (x_err)
`ifdef SWEEP_ERRLOG_EN
    ,
    .first_fail_vld (x_ff_vld),
    .first_fail_vec (x_ff_vec)
`endif
  );

  always_comb begin
    g_y = 1'b0;
    case (g_mode)
      0:       g_y = d_in[0] & d_in[1];
      1:       g_y = 1'b0;
      2:       g_y = 1'b1;
      default: g_y = g_tab[d_in];
    endcase
    d_out = g_y ^ g_glitch;
  end

  always_comb begin
    x_out = (x_mode == 0) ? (x_in[0] ^ x_in[1]) : x_tab[x_in];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected gate output for vector v under the given fault mode.
  function automatic bit gate_model(input int mode, input logic [3:0] tab, input int v);
    case (mode)
      0:       return (v == 3);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return tab[v];
    endcase
  endfunction

  task automatic run_sweep(input int mode, input bit glitch_on, input bit restart_at7);
    int exp_err = 0;
    int exp_first = -1;
    g_mode = mode;
    g_tab  = 4'($urandom_range(0, 15));
    for (int v = 0; v < 4; v++) begin
      if (gate_model(mode, g_tab, v) != (v == 3)) begin
        exp_err++;
        if (exp_first < 0) exp_first = v;
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("sweep_err_cleared", 32'(err_cnt), 32'd0);
    chk("sweep_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("sweep_dut_in_k%0d", k), 32'(d_in), 32'(k / 5));
      chk("sweep_not_done", 32'(done), 32'd0);
      g_glitch = (glitch_on && (k % 5 != 4)) ? 1'($urandom) : 1'b0;
      start    = (restart_at7 && k == 7);
      step();
      start = 1'b0;
    end
    g_glitch = 1'b0;
    chk("sweep_done", 32'(done), 32'd1);
    chk("sweep_busy_low", 32'(busy), 32'd0);
    chk("sweep_err_cnt", 32'(err_cnt), 32'(exp_err));
    chk("sweep_pass", 32'(pass), 32'(exp_err == 0));
`ifdef SWEEP_ERRLOG_EN
    chk("sweep_ff_vld", 32'(ff_vld), 32'(exp_first >= 0));
    chk("sweep_ff_vec", 32'(ff_vec), 32'(exp_first >= 0 ? exp_first : 0));
`endif
    step();
    chk("sweep_done_held", 32'(done), 32'd1);
  endtask

  task automatic run_xor(input int mode);
    int exp_err = 0;
    x_mode = mode;
    x_tab  = 4'($urandom_range(0, 15));
    for (int v = 0; v < 4; v++) begin
      bit y = (mode == 0) ? bit'((v & 1) ^ (v >> 1)) : x_tab[v];
      if (y != bit'(v == 1 || v == 2)) exp_err++;
    end
    x_start = 1'b1;
    step();
    x_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("xor_dut_in_k%0d", k), 32'(x_in), 32'(k));
      chk("xor_busy", 32'(x_busy), 32'd1);
      step();
    end
    chk("xor_done", 32'(x_done), 32'd1);
    chk("xor_err_cnt", 32'(x_err), 32'(exp_err));
    chk("xor_pass", 32'(x_pass), 32'(exp_err == 0));
  endtask

  initial begin
    #2;
    chk("rst_dut_in", 32'(d_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_no_done", 32'(done), 32'd0);

    run_sweep(0, 1'b0, 1'b0);
    run_sweep(1, 1'b0, 1'b0);
    run_sweep(2, 1'b0, 1'b0);
    run_sweep(0, 1'b0, 1'b1);
    run_sweep(0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) run_sweep(3, 1'b1, (i % 2) == 1);

    // Mid-sweep reset at vector 2
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 12; k++) step();
    chk("pre_rst_vec", 32'(d_in), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_dut_in", 32'(d_in), 32'd0);
    chk("arst_err", 32'(err_cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_sweep(0, 1'b0, 1'b0);

    run_xor(0);
    for (int i = 0; i < 3; i++) run_xor(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
